// File: rtl/uart_frame_loader.sv
// Framed UART byte-stream loader: sync word, 16-bit length, payload to BRAM port A, checksum.
// Optional ACK/NAK byte queue enabled by defining UART_FRAME_ACK_EN.
module uart_frame_loader #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned MAX_BYTES  = 16384,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
`ifdef UART_FRAME_ACK_EN
  input  logic        tx_busy,
  output logic        send_en,
  output logic [7:0]  send_data,
`endif
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [14:0] frame_len
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
  // Firing when the counter steps onto TIMEOUT_CYCLES-1 puts frame_err exactly there.
  localparam logic [31:0] TmoFire = 32'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {StIdle, StSync, StLenH, StLenL, StPayload, StCsum} state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [14:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        ram_we_q, ram_we_d;
  logic [13:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [14:0] frame_len_q, frame_len_d;
  logic [15:0] rx_len;

  assign rx_len = {len_hi_q, rx_data};

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    frame_len_d = frame_len_q;
    if (state_q != StIdle) tmo_d = tmo_q + 32'd1;

    if (rx_done) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (rx_data == SYNC0) begin
            state_d    = StSync;
            err_code_d = 2'd0;
          end
        end
        StSync: begin
          if (rx_data == SYNC1)      state_d = StLenH;
          else if (rx_data != SYNC0) state_d = StIdle;
        end
        StLenH: begin
          len_hi_d = rx_data;
          state_d  = StLenL;
        end
        StLenL: begin
          len_d = rx_len;
          if (rx_len == 16'd0 || rx_len > 16'(MAX_BYTES)) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = StIdle;
          end else begin
            idx_d   = '0;
            sum_d   = '0;
            state_d = StPayload;
          end
        end
        StPayload: begin
          ram_we_d    = 1'b1;
          ram_addr_d  = idx_q[13:0];
          ram_wdata_d = rx_data;
          sum_d       = sum_q + rx_data;
          idx_d       = idx_q + 15'd1;
          if ({1'b0, idx_q} + 16'd1 == len_q) state_d = StCsum;
        end
        StCsum: begin
          if (rx_data == sum_q) begin
            done_d      = 1'b1;
            frame_len_d = len_q[14:0];
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoFire) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
      state_d    = StIdle;
      tmo_d      = '0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      len_hi_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = err_code_q;
  assign frame_len  = frame_len_q;

`ifdef UART_FRAME_ACK_EN
  logic       ack_full_q, ack_full_d;
  logic [7:0] ack_byte_q, ack_byte_d;
  logic       send_en_q, send_en_d;
  logic [7:0] send_data_q, send_data_d;

  // Single-entry queue; a fresh result takes priority over draining the old one.
  always_comb begin
    ack_full_d  = ack_full_q;
    ack_byte_d  = ack_byte_q;
    send_en_d   = 1'b0;
    send_data_d = send_data_q;
    if (ack_full_q && !tx_busy) begin
      send_en_d   = 1'b1;
      send_data_d = ack_byte_q;
      ack_full_d  = 1'b0;
    end
    if (done_q) begin
      ack_full_d = 1'b1;
      ack_byte_d = 8'h06;
    end else if (err_q) begin
      ack_full_d = 1'b1;
      ack_byte_d = 8'h15;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_full_q  <= 1'b0;
      ack_byte_q  <= '0;
      send_en_q   <= 1'b0;
      send_data_q <= '0;
    end else begin
      ack_full_q  <= ack_full_d;
      ack_byte_q  <= ack_byte_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
    end
  end

  assign send_en   = send_en_q;
  assign send_data = send_data_q;
`endif

endmodule
